left_shift_4: RTL and testbench

Fixed logical left shift by four for the 16-bit datapath. It is used for immediate and offset scaling ahead of the ALU and PC-adder. The block has two result paths. A purely combinational result follows `in` with no clock involvement. A registered copy sits behind a one-entry valid/ready output stage so pipelined users can consume it. Both paths also report the bits shifted out, and the registered path reports an overflow flag.

---
 rtl/left_shift_4.sv | 66 ++++++
 tb/tb_left_shift_4.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/left_shift_4.sv
`default_nettype none
// ---------------------------------------------------------------------------
// left_shift_4 : fixed logical left shift by SHIFT with a one-entry
//                valid/ready registered output stage.
// Revision     : 1.0
// ---------------------------------------------------------------------------
module left_shift_4 #(
  parameter int WIDTH = 16,
  parameter int SHIFT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [SHIFT-1:0] spill,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_q,
  output logic [SHIFT-1:0] spill_q,
  output logic             ovf_q,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] w_out;
  logic [SHIFT-1:0] w_spill;
  logic             w_in_ready;
  logic             w_capture;

  logic [WIDTH-1:0] r_out_q;
  logic [SHIFT-1:0] r_spill_q;
  logic             r_ovf_q;
  logic             r_out_valid;

  assign w_out      = {in[WIDTH-SHIFT-1:0], {SHIFT{1'b0}}};
  assign w_spill    = in[WIDTH-1:WIDTH-SHIFT];
  // Ready depends only on the stage state and the consumer, never on in_valid.
  assign w_in_ready = !r_out_valid || out_ready;
  assign w_capture  = in_valid && w_in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_q     <= '0;
      r_spill_q   <= '0;
      r_ovf_q     <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_capture) begin
      r_out_q     <= w_out;
      r_spill_q   <= w_spill;
      r_ovf_q     <= |w_spill;
      r_out_valid <= 1'b1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out       = w_out;
  assign spill     = w_spill;
  assign in_ready  = w_in_ready;
  assign out_q     = r_out_q;
  assign spill_q   = r_spill_q;
  assign ovf_q     = r_ovf_q;
  assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_left_shift_4.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_left_shift_4 : scoreboard bench for left_shift_4 with random traffic.
// Revision        : 1.0
// ---------------------------------------------------------------------------
module tb_left_shift_4;

  localparam int WIDTH = 16;
  localparam int SHIFT = 4;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] out;
  logic [SHIFT-1:0] spill;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_q;
  logic [SHIFT-1:0] spill_q;
  logic             ovf_q;
  logic             out_valid;
  logic             out_ready;

  int checks   = 0;
  int failures = 0;

  // Expected registered results, packed as {ovf, spill, out}.
  logic [WIDTH+SHIFT:0] sb_q[$];
  logic                 mv;

  left_shift_4 #(.WIDTH(WIDTH), .SHIFT(SHIFT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (in),
    .out       (out),
    .spill     (spill),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_q     (out_q),
    .spill_q   (spill_q),
    .ovf_q     (ovf_q),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: multiply by 2**SHIFT modulo 2**WIDTH; the bits lost are the quotient.
  function automatic logic [WIDTH-1:0] ref_out(input logic [WIDTH-1:0] v);
    int unsigned p;
    p = (int'(v) * (2 ** SHIFT)) % (2 ** WIDTH);
    return p[WIDTH-1:0];
  endfunction

  function automatic logic [SHIFT-1:0] ref_spill(input logic [WIDTH-1:0] v);
    int unsigned d;
    d = int'(v) / (2 ** (WIDTH - SHIFT));
    return d[SHIFT-1:0];
  endfunction

  // One clock of traffic with the currently driven inputs; ends 1 ns after the edge.
  task automatic cycle();
    logic                 acc;
    logic [WIDTH+SHIFT:0] e;
    @(negedge clk);
    chk("in_ready", {31'd0, in_ready}, {31'd0, (!mv || out_ready)});
    chk("out_valid", {31'd0, out_valid}, {31'd0, mv});
    chk("out", {16'd0, out}, {16'd0, ref_out(in)});
    chk("spill", {28'd0, spill}, {28'd0, ref_spill(in)});
    acc = in_valid && (!mv || out_ready);
    e   = {(ref_spill(in) != 0), ref_spill(in), ref_out(in)};
    @(posedge clk);
    if (acc) begin
      sb_q.push_back(e);
      mv = 1'b1;
    end else if (out_ready) begin
      mv = 1'b0;
    end
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_result", {16'd0, out_q}, 32'hDEAD_0000);
      end else begin
        logic [WIDTH+SHIFT:0] e;
        e = sb_q.pop_front();
        chk("sb_out_q", {16'd0, out_q}, {16'd0, e[WIDTH-1:0]});
        chk("sb_spill_q", {28'd0, spill_q}, {28'd0, e[WIDTH+SHIFT-1:WIDTH]});
        chk("sb_ovf_q", {31'd0, ovf_q}, {31'd0, e[WIDTH+SHIFT]});
      end
    end
  end

  initial begin
    logic [WIDTH-1:0] vals[3];
    rst_n     = 1'b0;
    in        = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    mv        = 1'b0;

    // Combinational path with no reliance on clock edges.
    in = 16'h3FFF; #100;
    chk("comb_out_3fff", {16'd0, out}, 32'hFFF0);
    chk("comb_spill_3fff", {28'd0, spill}, 32'h3);
    in = 16'h0001; #100;
    chk("comb_out_0001", {16'd0, out}, 32'h0010);
    chk("comb_spill_0001", {28'd0, spill}, 32'h0);
    in = 16'h0000; #10;
    chk("comb_out_0000", {16'd0, out}, 32'h0000);
    in = 16'hFFFF; #10;
    chk("comb_out_ffff", {16'd0, out}, 32'hFFF0);
    chk("comb_spill_ffff", {28'd0, spill}, 32'hF);
    in = 16'h0FFF; #10;
    chk("comb_out_0fff", {16'd0, out}, 32'hFFF0);
    chk("comb_spill_0fff", {28'd0, spill}, 32'h0);

    chk("rst_out_q", {16'd0, out_q}, 32'h0);
    chk("rst_spill_q", {28'd0, spill_q}, 32'h0);
    chk("rst_ovf_q", {31'd0, ovf_q}, 32'h0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'h0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'h1);

    @(posedge clk); #1;
    rst_n = 1'b1;

    // First capture.
    in = 16'h3FFF; in_valid = 1'b1; out_ready = 1'b1;
    cycle();
    chk("cap_out_q", {16'd0, out_q}, 32'hFFF0);
    chk("cap_spill_q", {28'd0, spill_q}, 32'h3);
    chk("cap_ovf_q", {31'd0, ovf_q}, 32'h1);
    chk("cap_out_valid", {31'd0, out_valid}, 32'h1);

    // Back-to-back at full throughput.
    vals[0] = 16'h0001; vals[1] = 16'h0123; vals[2] = 16'hF000;
    for (int i = 0; i < 3; i++) begin
      in = vals[i];
      cycle();
      chk("b2b_out_q", {16'd0, out_q}, {16'd0, ref_out(vals[i])});
      chk("b2b_ovf_q", {31'd0, ovf_q}, {31'd0, (i == 2)});
    end
    chk("b2b_spill_q_last", {28'd0, spill_q}, 32'hF);
    in_valid = 1'b0;
    cycle();

    // Stall: result held while in changes.
    in = 16'h0001; in_valid = 1'b1; out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in = 16'($urandom);
      cycle();
      chk("stall_in_ready", {31'd0, in_ready}, 32'h0);
      chk("stall_out_q", {16'd0, out_q}, 32'h0010);
    end
    out_ready = 1'b1; in_valid = 1'b0;
    cycle();
    chk("drain_out_valid", {31'd0, out_valid}, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      in        = 16'($urandom);
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    out_ready = 1'b1; in_valid = 1'b0;
    cycle();
    chk("rand_queue_empty", sb_q.size(), 32'd0);

    // Asynchronous reset in the middle of a stall.
    in = 16'h0001; in_valid = 1'b1; out_ready = 1'b1;
    cycle();
    in_valid = 1'b0; out_ready = 1'b0;
    cycle();
    chk("pre_rst_out_q", {16'd0, out_q}, 32'h0010);
    chk("pre_rst_out_valid", {31'd0, out_valid}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_q", {16'd0, out_q}, 32'h0);
    chk("async_rst_ovf_q", {31'd0, ovf_q}, 32'h0);
    chk("async_rst_out_valid", {31'd0, out_valid}, 32'h0);
    in = 16'h0ABC; #1;
    chk("rst_comb_out", {16'd0, out}, 32'hABC0);
    sb_q.delete();
    mv = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Capture after reset release.
    in = 16'h1234; in_valid = 1'b1; out_ready = 1'b1;
    cycle();
    chk("post_rst_out_q", {16'd0, out_q}, 32'h2340);
    in_valid = 1'b0;
    cycle();
    cycle();
    chk("final_queue_empty", sb_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
